// File: rtl/uart_frame_parser.sv
// Frame parser behind uart_rcvr_top: SOF, LEN, payload[LEN], CSUM with length/checksum/timeout checks.
// Define UART_FRAME_PARSER_STATS_EN to add saturating ok_count/err_count outputs.
module uart_frame_parser #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] SOF_BYTE = 8'hA5,
  parameter int               MAX_LEN  = 32,
  parameter int               TIMEOUT  = 8192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] r_data,
  input  logic             rx_fifo_empty,
  output logic             rd_uart,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code
`ifdef UART_FRAME_PARSER_STATS_EN
  ,
  output logic [15:0]      ok_count,
  output logic [15:0]      err_count
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;

  state_t           state;
  logic [WIDTH-1:0] remaining;
  logic [7:0]       sum;
  logic [TW-1:0]    idle_cnt;

  logic stalled;
  logic accept;
  logic len_bad;
  logic idle_hold;
  logic timed_out;

  // A payload byte may only be popped once the output register is free or being drained.
  assign stalled   = out_valid && !out_ready;
  assign accept    = (state != PAYLOAD) || !stalled;
  assign rd_uart   = !rx_fifo_empty && accept;
  assign len_bad   = (r_data == '0) || (r_data > WIDTH'(MAX_LEN));
  assign idle_hold = (state == PAYLOAD) && stalled;
  assign timed_out = (state != HUNT) && !rd_uart && !idle_hold &&
                     (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      remaining <= '0;
      sum       <= '0;
      idle_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (state == HUNT || rd_uart)
        idle_cnt <= '0;
      else if (!idle_hold)
        idle_cnt <= idle_cnt + 1'b1;

      if (timed_out) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= HUNT;
        idle_cnt  <= '0;
      end else if (rd_uart) begin
        case (state)
          HUNT: begin
            if (r_data == SOF_BYTE)
              state <= LEN;
          end
          LEN: begin
            if (len_bad) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= HUNT;
            end else begin
              remaining <= r_data;
              sum       <= r_data[7:0];
              state     <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            out_data  <= r_data;
            out_valid <= 1'b1;
            sum       <= sum + r_data[7:0];
            remaining <= remaining - 1'b1;
            if (remaining == WIDTH'(1))
              state <= CSUM;
          end
          CSUM: begin
            if (r_data[7:0] == sum) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef UART_FRAME_PARSER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ok_count  <= 16'd0;
      err_count <= 16'd0;
    end else begin
      if (frame_ok && ok_count != 16'hFFFF)
        ok_count <= ok_count + 16'd1;
      if (frame_err && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: whole-stream frame model plus per-cycle stream/pulse compare.
module tb_uart_frame_parser;

  localparam int         WIDTH   = 8;
  localparam int         MAX_LEN = 32;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] SOF     = 8'hA5;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] r_data;
  logic             rx_fifo_empty;
  logic             rd_uart;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             frame_ok;
  logic             frame_err;
  logic [1:0]       err_code;

  uart_frame_parser #(
    .WIDTH   (WIDTH),
    .SOF_BYTE(SOF),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .r_data       (r_data),
    .rx_fifo_empty(rx_fifo_empty),
    .rd_uart      (rd_uart),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] stream[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pay_bytes[$];
  int         ev_code[int];
  bit         is_pay[int];
  int         pop_count;
  bit         pop_pending;

  int         sched_cyc[$];
  int         sched_code[$];
  bit         m_valid;
  logic [7:0] m_data;
  int         last_err;

  int ready_mode;
  int hold_len;
  int hold_cnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int ev_of(int idx);
    return ev_code.exists(idx) ? ev_code[idx] : -1;
  endfunction

  // Frame-level parse of a whole burst: which pops are payload and which pop ends a frame.
  function automatic void parse();
    int n, i, len, sum;
    ev_code.delete();
    is_pay.delete();
    pay_bytes.delete();
    n = stream.size();
    i = 0;
    while (i < n) begin
      if (stream[i] != SOF) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        ev_code[n-1] = 3;
        break;
      end
      len = int'(stream[i+1]);
      if (len == 0 || len > MAX_LEN) begin
        ev_code[i+1] = 1;
        i += 2;
        continue;
      end
      sum = len;
      for (int k = 0; k < len && i + 2 + k < n; k++) begin
        is_pay[i+2+k] = 1'b1;
        pay_bytes.push_back(stream[i+2+k]);
        sum += int'(stream[i+2+k]);
      end
      if (i + 2 + len >= n) begin
        ev_code[n-1] = 3;
        break;
      end
      ev_code[i+2+len] = ((sum % 256) == int'(stream[i+2+len])) ? 0 : 2;
      i += 3 + len;
    end
  endfunction

  task automatic apply_stimulus();
    r_data        = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    rx_fifo_empty = (fifo_q.size() == 0);
    case (ready_mode)
      1: out_ready = (fifo_q.size() != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      2: begin
        if (m_valid && hold_cnt < hold_len) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  endtask

  // Per-cycle comparison against the model, then advance the model across the coming edge.
  task automatic check_output();
    bit exp_rd;
    int code;
    exp_rd = (fifo_q.size() != 0) && !(m_valid && !out_ready && is_pay.exists(pop_count));
    check("rd_uart", rd_uart, exp_rd);
    check("out_valid", out_valid, m_valid);
    if (m_valid) check("out_data", out_data, m_data);
    code = -1;
    if (sched_cyc.size() != 0 && sched_cyc[0] == cyc) begin
      code = sched_code[0];
      void'(sched_cyc.pop_front());
      void'(sched_code.pop_front());
    end
    check("frame_ok", frame_ok, code == 0);
    check("frame_err", frame_err, code > 0);
    if (code > 0) last_err = code;
    check("err_code", err_code, last_err);

    pop_pending = rd_uart && (fifo_q.size() != 0);
    if (m_valid && out_ready) m_valid = 1'b0;
    if (pop_pending) begin
      if (ev_code.exists(pop_count)) begin
        sched_cyc.push_back(cyc + 1 + ((ev_code[pop_count] == 3) ? TIMEOUT : 0));
        sched_code.push_back(ev_code[pop_count]);
      end
      if (is_pay.exists(pop_count)) begin
        m_valid = 1'b1;
        m_data  = fifo_q[0];
      end
    end
  endtask

  task automatic step();
    pop_pending = 1'b0;
    @(negedge clk);
    if (reset) check_output();
    @(posedge clk);
    cyc++;
    #1;
    if (pop_pending) begin
      void'(fifo_q.pop_front());
      pop_count++;
    end
    apply_stimulus();
  endtask

  task automatic load();
    parse();
    fifo_q    = stream;
    pop_count = 0;
    hold_cnt  = 0;
    apply_stimulus();
  endtask

  task automatic run_burst(string tag);
    bit done;
    done = 1'b0;
    load();
    for (int c = 0; c < 4000 && !done; c++) begin
      step();
      done = (fifo_q.size() == 0) && (sched_cyc.size() == 0) && !m_valid;
    end
    check({tag, "_drained"}, done, 1'b1);
    for (int c = 0; c < TIMEOUT + 4; c++) step();
  endtask

  task automatic add_frame(int kind);
    int         len, s, cut;
    logic [7:0] b;
    case (kind)
      2: begin
        stream.push_back(SOF);
        stream.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end
      3: begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          b = 8'($urandom_range(0, 255));
          stream.push_back((b == SOF) ? 8'h00 : b);
        end
      end
      default: begin
        len = ($urandom_range(0, 7) == 0) ? MAX_LEN : int'($urandom_range(1, 8));
        cut = (kind == 4) ? int'($urandom_range(0, len + 1)) : len + 2;
        stream.push_back(SOF);
        if (cut > 0) stream.push_back(8'(len));
        s = len;
        for (int k = 0; k < len && k + 1 < cut; k++) begin
          b = ($urandom_range(0, 4) == 0) ? SOF : 8'($urandom_range(0, 255));
          stream.push_back(b);
          s += int'(b);
        end
        if (kind == 1) s += int'($urandom_range(1, 255));
        if (kind != 4) stream.push_back(8'(s));
      end
    endcase
  endtask

  initial begin
    reset         = 1'b0;
    r_data        = 8'h00;
    rx_fifo_empty = 1'b1;
    out_ready     = 1'b1;
    ready_mode    = 0;
    hold_len      = 0;
    hold_cnt      = 0;
    pop_count     = 0;
    m_valid       = 1'b0;
    m_data        = 8'h00;
    last_err      = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_err_code", err_code, 2'd0);
    check("reset_pulses", {frame_ok, frame_err}, 2'b00);
    reset = 1'b1;
    repeat (3) step();

    $display("[TB] good frame");
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    parse();
    check("pin_good_len", pay_bytes.size(), 3);
    check("pin_good_b2", pay_bytes[2], 8'h33);
    check("pin_good_ev", ev_of(5), 0);
    run_burst("good");

    $display("[TB] bad checksum");
    stream = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    parse();
    check("pin_bad_ev", ev_of(4), 2);
    run_burst("badsum");

    $display("[TB] length errors");
    stream = '{8'hA5, 8'h00, 8'hA5, 8'd40};
    parse();
    check("pin_len0_ev", ev_of(1), 1);
    check("pin_len40_ev", ev_of(3), 1);
    check("pin_len_nopay", pay_bytes.size(), 0);
    run_burst("len");

    $display("[TB] backpressure");
    stream = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
    parse();
    check("pin_bp_ev", ev_of(4), 0);
    ready_mode = 2;
    hold_len   = 10;
    run_burst("bp10");
    hold_len   = 3 * TIMEOUT;
    run_burst("bp_long");
    ready_mode = 0;

    $display("[TB] timeout");
    stream = '{8'hA5, 8'h04, 8'h01};
    parse();
    check("pin_to_ev", ev_of(2), 3);
    run_burst("timeout");
    stream = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    run_burst("after_timeout");

    $display("[TB] garbage then reset mid-payload");
    stream = '{8'h13, 8'hA5, 8'h00, 8'h00, 8'hFF, 8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h14};
    load();
    for (int c = 0; c < 200 && pop_count < 9; c++) step();
    check("rst_reached_payload", pop_count >= 9, 1'b1);
    reset = 1'b0;
    #1;
    fifo_q.delete();
    ev_code.delete();
    is_pay.delete();
    sched_cyc.delete();
    sched_code.delete();
    m_valid   = 1'b0;
    last_err  = 0;
    pop_count = 0;
    apply_stimulus();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_pulses", {frame_ok, frame_err}, 2'b00);
    check("rst_err_code", err_code, 2'd0);
    check("rst_rd_uart", rd_uart, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    for (int c = 0; c < 2 * TIMEOUT; c++) step();
    stream = '{8'hA5, 8'h02, 8'hA5, 8'h5A, 8'h01};
    run_burst("after_reset");

    $display("[TB] random bursts");
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int nf;
      stream.delete();
      nf = int'($urandom_range(1, 4));
      for (int f = 0; f < nf; f++) add_frame(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) add_frame(4);
      run_burst("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of uart_rcvr_top and drains its receive FIFO.
- Delineates byte frames of the form SOF, LEN, payload[LEN], CSUM, and checks length and checksum.
- Forwards payload bytes on a valid/ready stream.
- Reports frame completion or error as one-cycle pulses to the consuming logic.

Parameters:
- WIDTH, 8, byte width; must match uart_rcvr_top WIDTH.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 32, largest accepted LEN value (1..255).
- TIMEOUT, 8192, idle clocks allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- r_data  in  WIDTH  head byte of the receive FIFO; valid whenever rx_fifo_empty==0
- rx_fifo_empty  in  1  receive FIFO empty flag
- rd_uart  out  1  pop strobe to the receive FIFO; combinational
- out_data  out  WIDTH  payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- frame_ok  out  1  one-cycle pulse: frame received with good checksum
- frame_err  out  1  one-cycle pulse: frame aborted
- err_code  out  2  cause of the last error; 0 none, 1 length, 2 checksum, 3 timeout; held until the next error or reset

Behaviour:
- Reset values: all registered outputs 0; state HUNT; checksum and counters cleared.
- Reset is asynchronous; asserting it mid-frame aborts the frame with no pulse.
- Pop rule: rd_uart = !rx_fifo_empty && accept, where accept is 1 in HUNT, LEN and CSUM.
- In PAYLOAD, accept = (!out_valid || out_ready).
- A byte is consumed on the rising edge where rd_uart==1. Back-to-back pops on consecutive cycles are legal.
- States and transitions:
  - HUNT: a popped byte equal to SOF_BYTE -> LEN; any other byte is discarded silently.
  - LEN: popped value L.
    - L==0 or L>MAX_LEN -> frame_err pulse, err_code=1, HUNT.
    - Otherwise store L, set sum=L, go to PAYLOAD.
  - PAYLOAD:
    - Each popped byte is loaded into out_data with out_valid=1, added to sum, and the remaining count is decremented.
    - After the L-th byte -> CSUM.
  - CSUM:
    - Popped byte equal to sum[7:0] -> frame_ok pulse.
    - Otherwise -> frame_err pulse, err_code=2.
    - In both cases go to HUNT.
- Checksum: 8-bit modular sum of LEN and all payload bytes; carries are discarded.
- Output stream:
  - out_valid stays high until out_ready is sampled high.
  - out_data is stable while out_valid=1 && !out_ready.
  - A new byte may load in the same cycle the old one is accepted (full throughput).
- Payload bytes are forwarded before the checksum is known. The consumer discards the frame on frame_err.
- frame_ok/frame_err are asserted the cycle after the CSUM pop; they never assert together.
- Timeout:
  - The counter runs in LEN, PAYLOAD and CSUM, and clears on every pop.
  - It does not count in PAYLOAD while the parser is stalled by out_valid && !out_ready.
  - Reaching TIMEOUT -> frame_err, err_code=3, HUNT.
  - In HUNT the counter is held at 0.
- A SOF_BYTE value appearing inside LEN, PAYLOAD or CSUM is treated as data; there is no resynchronisation.
- Latency: a payload byte appears on out_data 1 cycle after its pop.

Optional Feature:
- Macro UART_FRAME_PARSER_STATS_EN.
- When defined, adds outputs ok_count[15:0] and err_count[15:0], which increment on frame_ok and frame_err respectively.
  - Both saturate at 16'hFFFF.
  - Both are cleared by reset.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame: FIFO holds A5 03 11 22 33 69, out_ready=1.
  - Expect out_data 11,22,33 on 3 consecutive valid cycles.
  - Expect frame_ok=1 for one cycle, err_code stays 0.
- Bad checksum: FIFO holds A5 02 10 20 00.
  - Expect 10,20 forwarded, then frame_err pulse, err_code=2, state HUNT.
- Length error: FIFO holds A5 00, then A5 with 8'd40 (MAX_LEN=32).
  - Expect frame_err each time, err_code=1, no out_valid.
- Backpressure: good frame A5 02 AA BB 67, out_ready held 0 for 10 cycles after the first byte.
  - Expect out_data=AA held stable.
  - Expect rd_uart=0 during the stall and no timeout.
  - Expect BB and frame_ok after out_ready rises.
- Timeout (TIMEOUT=16): FIFO holds A5 04 01, then stays empty.
  - Expect frame_err with err_code=3 exactly 16 cycles after the last pop.
  - A following good frame then parses correctly.
- Garbage plus reset: bytes 00 FF A5 01 preceded by junk are parsed from the A5. Assert reset mid-payload.
  - Expect all outputs 0 immediately, with no pulse.
